lsu_dcache_arbiter: RTL and testbench

- Sits directly downstream of the store buffer's commit port and beside the load pipe.
- Arbitrates load requests and committed-store requests onto the single dcache request channel using the addr_ok/data_ok handshake.
- Tracks outstanding requests in order, so each dcache data_ok is routed to the correct requester.
- Drops responses of loads squashed by flush; committed stores are never squashed.

---
 rtl/lsu_dcache_arbiter.sv | 150 +++++++++++++++
 tb/tb_lsu_dcache_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dcache_arbiter.sv
// lsu_dcache_arbiter
// Merges load-pipe requests and committed store-buffer requests onto a single
// dcache request channel that uses the addr_ok/data_ok handshake. Each accepted
// request is recorded in an in-order FIFO. This lets every data_ok be routed
// back to the requester that issued it. When a flush occurs, loads that are
// still in flight are marked killed, so their responses are dropped silently.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   flush                  squashes in-flight loads and blocks new load grants
//   ld_*                   load request (req/addr/size) and response (addr_ok/data_ok/rdata)
//   st_*                   store commit request and response; st_buffer_full forces priority
//   dc_*                   dcache request channel and response inputs
//   protocol_err           sticky; set when data_ok arrives with nothing outstanding
module lsu_dcache_arbiter #(
  parameter int unsigned OUTSTANDING  = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        ld_addr_ok,
  output logic        ld_data_ok,
  output logic [31:0] ld_rdata,
  input  logic        st_req,
  input  logic [3:0]  st_wstrb,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic        st_buffer_full,
  output logic        st_addr_ok,
  output logic        st_data_ok,
  output logic        dc_req,
  output logic        dc_wr,
  output logic [2:0]  dc_size,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  input  logic        dc_addr_ok,
  input  logic        dc_data_ok,
  input  logic [31:0] dc_rdata,
  output logic        protocol_err
);

  localparam int unsigned PtrW = $clog2(OUTSTANDING);
  localparam int unsigned CntW = $clog2(OUTSTANDING + 1);
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(OUTSTANDING);
  localparam logic [StvW-1:0] StvMax = StvW'(STARVE_LIMIT);

  logic [OUTSTANDING-1:0] is_store_q, is_store_d;
  logic [OUTSTANDING-1:0] killed_q, killed_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [StvW-1:0]        starve_q, starve_d;
  logic                   protocol_err_q, protocol_err_d;

  logic ld_eff, st_grant, ld_grant, accept, pop, head_store, head_killed, fifo_empty;

  // Grant and request mux
  always_comb begin
    ld_eff   = ld_req & ~flush;
    st_grant = st_req & (~ld_eff | (starve_q == StvMax) | st_buffer_full);
    ld_grant = ld_eff & ~st_grant;
    dc_req   = (ld_eff | st_req) & (count_q != CntMax);
    dc_wr    = st_grant;
    dc_size  = '0;
    dc_addr  = '0;
    dc_wstrb = '0;
    dc_wdata = '0;
    if (st_grant) begin
      dc_size  = st_size;
      dc_addr  = st_addr;
      dc_wstrb = st_wstrb;
      dc_wdata = st_wdata;
    end else if (ld_grant) begin
      dc_size = ld_size;
      dc_addr = ld_addr;
    end
    accept     = dc_req & dc_addr_ok;
    ld_addr_ok = accept & ld_grant;
    st_addr_ok = accept & st_grant;
  end

  // Response routing from the head entry; the kill bit used here is the
  // pre-flush value, so a load answered in the flush cycle is still delivered.
  always_comb begin
    fifo_empty  = (count_q == '0);
    head_store  = is_store_q[rd_ptr_q];
    head_killed = killed_q[rd_ptr_q];
    pop         = dc_data_ok & ~fifo_empty;
    st_data_ok  = pop & head_store;
    ld_data_ok  = pop & ~head_store & ~head_killed;
    ld_rdata    = ld_data_ok ? dc_rdata : '0;
    protocol_err = protocol_err_q;
  end

  always_comb begin
    is_store_d     = is_store_q;
    killed_d       = killed_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    starve_d       = '0;
    protocol_err_d = protocol_err_q | (dc_data_ok & fifo_empty);

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    // Killing stale (invalid) load slots is harmless: a push rewrites the bit.
    if (flush) killed_d = killed_q | ~is_store_q;
    if (accept) begin
      is_store_d[wr_ptr_q] = dc_wr;
      killed_d[wr_ptr_q]   = 1'b0;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !accept) begin
      count_d = count_q - 1'b1;
    end

    if (st_req && !st_addr_ok) begin
      starve_d = (starve_q == StvMax) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_store_q     <= '0;
      killed_q       <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      starve_q       <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      is_store_q     <= is_store_d;
      killed_q       <= killed_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      starve_q       <= starve_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// Testbench for lsu_dcache_arbiter. It applies directed sequences and
// randomized stimulus. Every output is compared each cycle against a
// queue-based reference model of the outstanding requests.
module tb_lsu_dcache_arbiter;
  localparam int unsigned OUTSTANDING  = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_size;
  logic        ld_addr_ok, ld_data_ok;
  logic [31:0] ld_rdata;
  logic        st_req;
  logic [3:0]  st_wstrb;
  logic [2:0]  st_size;
  logic [31:0] st_addr, st_wdata;
  logic        st_buffer_full, st_addr_ok, st_data_ok;
  logic        dc_req, dc_wr;
  logic [2:0]  dc_size;
  logic [3:0]  dc_wstrb;
  logic [31:0] dc_addr, dc_wdata;
  logic        dc_addr_ok, dc_data_ok;
  logic [31:0] dc_rdata;
  logic        protocol_err;

  always #5 clk = ~clk;

  lsu_dcache_arbiter #(
    .OUTSTANDING (OUTSTANDING),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .ld_req        (ld_req),
    .ld_addr       (ld_addr),
    .ld_size       (ld_size),
    .ld_addr_ok    (ld_addr_ok),
    .ld_data_ok    (ld_data_ok),
    .ld_rdata      (ld_rdata),
    .st_req        (st_req),
    .st_wstrb      (st_wstrb),
    .st_size       (st_size),
    .st_addr       (st_addr),
    .st_wdata      (st_wdata),
    .st_buffer_full(st_buffer_full),
    .st_addr_ok    (st_addr_ok),
    .st_data_ok    (st_data_ok),
    .dc_req        (dc_req),
    .dc_wr         (dc_wr),
    .dc_size       (dc_size),
    .dc_wstrb      (dc_wstrb),
    .dc_addr       (dc_addr),
    .dc_wdata      (dc_wdata),
    .dc_addr_ok    (dc_addr_ok),
    .dc_data_ok    (dc_data_ok),
    .dc_rdata      (dc_rdata),
    .protocol_err  (protocol_err)
  );

  typedef struct packed {
    logic is_store;
    logic killed;
  } ent_t;

  ent_t        model_q[$];
  int          starve;
  bit          perr;
  int          n_vec, n_err;
  logic        seen_ld_ok, seen_st_ok, seen_ld_dok, seen_st_dok;
  logic [31:0] seen_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_size = '0;
    st_req = 1'b0; st_wstrb = '0; st_size = '0; st_addr = '0; st_wdata = '0;
    st_buffer_full = 1'b0; dc_addr_ok = 1'b0; dc_data_ok = 1'b0; dc_rdata = '0;
  endtask

  // One clock: compare at the falling edge, advance the model, resume after the rising edge.
  task automatic run_cycle();
    bit          ld_eff, st_win, ld_win, req, acc, e_ld_dok, e_st_dok;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_size;
    logic [3:0]  e_wstrb;
    @(negedge clk);
    seen_ld_ok = ld_addr_ok; seen_st_ok = st_addr_ok;
    seen_ld_dok = ld_data_ok; seen_st_dok = st_data_ok; seen_rdata = ld_rdata;
    if (reset) begin
      model_q.delete();
      starve = 0;
      perr   = 0;
    end else begin
      ld_eff = ld_req && !flush;
      st_win = st_req && (!ld_eff || starve == int'(STARVE_LIMIT) || st_buffer_full);
      ld_win = ld_eff && !st_win;
      req    = (ld_eff || st_req) && model_q.size() < int'(OUTSTANDING);
      acc    = req && dc_addr_ok;
      e_addr = st_win ? st_addr : (ld_win ? ld_addr : 32'h0);
      e_size = st_win ? st_size : (ld_win ? ld_size : 3'h0);
      e_wstrb = st_win ? st_wstrb : 4'h0;
      e_wdata = st_win ? st_wdata : 32'h0;
      e_ld_dok = 0;
      e_st_dok = 0;
      if (dc_data_ok && model_q.size() > 0) begin
        e_st_dok = model_q[0].is_store;
        e_ld_dok = !model_q[0].is_store && !model_q[0].killed;
      end
      check("dc_req", {31'h0, dc_req}, {31'h0, req});
      check("dc_wr", {31'h0, dc_wr}, {31'h0, st_win});
      check("dc_addr", dc_addr, e_addr);
      check("dc_size", {29'h0, dc_size}, {29'h0, e_size});
      check("dc_wstrb", {28'h0, dc_wstrb}, {28'h0, e_wstrb});
      check("dc_wdata", dc_wdata, e_wdata);
      check("ld_addr_ok", {31'h0, ld_addr_ok}, {31'h0, acc && ld_win});
      check("st_addr_ok", {31'h0, st_addr_ok}, {31'h0, acc && st_win});
      check("ld_data_ok", {31'h0, ld_data_ok}, {31'h0, e_ld_dok});
      check("st_data_ok", {31'h0, st_data_ok}, {31'h0, e_st_dok});
      check("ld_rdata", ld_rdata, e_ld_dok ? dc_rdata : 32'h0);
      check("protocol_err", {31'h0, protocol_err}, {31'h0, perr});
      if (dc_data_ok) begin
        if (model_q.size() == 0) perr = 1;
        else void'(model_q.pop_front());
      end
      if (flush) foreach (model_q[i]) if (!model_q[i].is_store) model_q[i].killed = 1'b1;
      if (acc) model_q.push_back('{is_store: st_win, killed: 1'b0});
      if (st_req && !(acc && st_win)) starve = (starve < int'(STARVE_LIMIT)) ? starve + 1 : starve;
      else starve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    run_cycle();
    run_cycle();
    reset = 1'b0;
  endtask

  task automatic rand_inputs(input int p_ld, input int p_st, input int p_aok, input int p_dok,
                             input int p_fl);
    ld_req     = ($urandom_range(99) < p_ld);
    ld_addr    = $urandom;
    ld_size    = 3'($urandom_range(7));
    st_req     = ($urandom_range(99) < p_st);
    st_addr    = $urandom;
    st_wdata   = $urandom;
    st_wstrb   = 4'($urandom_range(15));
    st_size    = 3'($urandom_range(7));
    st_buffer_full = ($urandom_range(99) < 10);
    flush      = ($urandom_range(99) < p_fl);
    dc_addr_ok = ($urandom_range(99) < p_aok);
    dc_rdata   = $urandom;
    if (model_q.size() > 0) dc_data_ok = ($urandom_range(99) < p_dok);
    else dc_data_ok = ($urandom_range(99) < 2);
  endtask

  initial begin
    int first_st;
    n_vec = 0;
    n_err = 0;
    do_reset();

    // Reset state with idle inputs
    run_cycle();

    // Single load, answered two cycles later
    ld_req = 1'b1; ld_addr = 32'h8000_1000; ld_size = 3'd2; dc_addr_ok = 1'b1;
    run_cycle();
    check("load_only_addr_ok", {31'h0, seen_ld_ok}, 32'h1);
    idle_inputs();
    run_cycle();
    dc_data_ok = 1'b1; dc_rdata = 32'hDEAD_BEEF;
    run_cycle();
    check("load_only_data_ok", {31'h0, seen_ld_dok}, 32'h1);
    check("load_only_rdata", seen_rdata, 32'hDEAD_BEEF);
    idle_inputs();
    run_cycle();

    // Starvation: store must win exactly on cycle STARVE_LIMIT
    first_st = -1;
    for (int c = 0; c < 20 && first_st < 0; c++) begin
      ld_req = 1'b1; ld_addr = 32'h1000 + 32'(c * 4); st_req = 1'b1; st_addr = 32'h2000;
      st_wdata = 32'h1234_5678; st_wstrb = 4'hf; dc_addr_ok = 1'b1;
      dc_data_ok = (model_q.size() > 0);
      run_cycle();
      if (seen_st_ok) first_st = c;
    end
    check("starve_grant_cycle", 32'(first_st), 32'(STARVE_LIMIT));

    // Store-buffer-full forces the store at once
    st_buffer_full = 1'b1;
    dc_data_ok = (model_q.size() > 0);
    run_cycle();
    check("buffer_full_grant", {31'h0, seen_st_ok}, 32'h1);
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      dc_data_ok = (model_q.size() > 0);
      run_cycle();
    end

    // Empty-FIFO response sets the sticky error; reset clears it
    idle_inputs();
    dc_data_ok = 1'b1;
    run_cycle();
    idle_inputs();
    run_cycle();
    check("protocol_err_sticky", {31'h0, protocol_err}, 32'h1);
    do_reset();
    run_cycle();

    // Randomized phases: balanced, congested (fills FIFO), flush-heavy
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 500; c++) begin
        case (ph)
          0: rand_inputs(60, 50, 70, 50, 5);
          1: rand_inputs(80, 70, 90, 15, 3);
          default: rand_inputs(70, 40, 80, 40, 25);
        endcase
        if ($urandom_range(299) == 0) reset = 1'b1;
        run_cycle();
        reset = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
